// File: rtl/escaner_display_4d.sv
// Four-digit multiplexed display scanner: time-slots each digit, blanks the slot start,
// optionally suppresses leading zeros and swaps in new data only at frame boundaries.
module escaner_display_4d #(
  parameter int P_DIV   = 50000,
  parameter int P_BLANK = 500
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [15:0] i_dato,
  input  logic        i_carga,
  input  logic        i_habilitar,
  input  logic        i_supr_ceros,
  output logic [3:0]  o_bits,
  output logic [3:0]  o_anodos,
  output logic [1:0]  o_digito,
  output logic        o_blanco,
  output logic        o_fin_trama
);

  localparam int CW = $clog2(P_DIV);
  localparam logic [CW-1:0] CNT_MAX   = CW'(P_DIV - 1);
  localparam logic [CW-1:0] BLANK_LIM = CW'(P_BLANK);

  logic [CW-1:0] cnt;
  logic [1:0]    dig;
  logic [15:0]   shadow;
  logic [15:0]   display;
  logic          fin_trama;
  logic          rst_hold;
  logic          slot_end;
  logic          frame_end;
  logic [3:1]    upper_zero;
  logic          suppressed;
  logic          blank;
  logic [3:0]    anodos;

  assign slot_end  = i_habilitar && (cnt == CNT_MAX);
  assign frame_end = slot_end && (dig == 2'd3);

  // rst_hold keeps the anodes dark right after reset even when P_BLANK is zero
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt       <= '0;
      dig       <= 2'd0;
      shadow    <= 16'h0000;
      display   <= 16'h0000;
      fin_trama <= 1'b0;
      rst_hold  <= 1'b1;
    end else begin
      if (i_carga)
        shadow <= i_dato;
      if (frame_end)
        display <= i_carga ? i_dato : shadow;
      fin_trama <= frame_end;
      if (i_habilitar) begin
        rst_hold <= 1'b0;
        if (slot_end) begin
          cnt <= '0;
          dig <= dig + 2'd1;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

  assign upper_zero[3] = (display[15:12] == 4'h0);
  assign upper_zero[2] = upper_zero[3] && (display[11:8] == 4'h0);
  assign upper_zero[1] = upper_zero[2] && (display[7:4] == 4'h0);

  always_comb begin
    suppressed = 1'b0;
    case (dig)
      2'd1:    suppressed = i_supr_ceros && upper_zero[1];
      2'd2:    suppressed = i_supr_ceros && upper_zero[2];
      2'd3:    suppressed = i_supr_ceros && upper_zero[3];
      default: suppressed = 1'b0;
    endcase
  end

  assign blank = (cnt < BLANK_LIM) || !i_habilitar || suppressed || rst_hold;

  always_comb begin
    anodos = 4'b1111;
    if (!blank)
      anodos[dig] = 1'b0;
  end

  assign o_anodos    = anodos;
  assign o_blanco    = blank;
  assign o_bits      = display[{dig, 2'b00} +: 4];
  assign o_digito    = dig;
  assign o_fin_trama = fin_trama;

endmodule

// File: tb/tb_escaner_display_4d.sv
// Bench for escaner_display_4d: directed scenarios then random traffic, all checked
// against a position-based model (one counter of enabled cycles within a frame).
module tb_escaner_display_4d;

  localparam int P_DIV   = 8;
  localparam int P_BLANK = 2;
  localparam int FRAME   = 4 * P_DIV;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic [15:0] i_dato;
  logic        i_carga;
  logic        i_habilitar;
  logic        i_supr_ceros;
  logic [3:0]  o_bits;
  logic [3:0]  o_anodos;
  logic [1:0]  o_digito;
  logic        o_blanco;
  logic        o_fin_trama;

  int n_assert = 0;
  int n_fail   = 0;

  // model state: position inside the frame, stored words, pending pulse
  int          m_pos;
  logic [15:0] m_shadow;
  logic [15:0] m_display;
  logic        m_fin;

  escaner_display_4d #(.P_DIV(P_DIV), .P_BLANK(P_BLANK)) dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_dato       (i_dato),
    .i_carga      (i_carga),
    .i_habilitar  (i_habilitar),
    .i_supr_ceros (i_supr_ceros),
    .o_bits       (o_bits),
    .o_anodos     (o_anodos),
    .o_digito     (o_digito),
    .o_blanco     (o_blanco),
    .o_fin_trama  (o_fin_trama)
  );

  always #5 i_clk = ~i_clk;

  task automatic compare(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %h expected %h (pos %0d)", tag, obs, exp, m_pos);
    end
  endtask

  task automatic checkOutput();
    int          cnt_e;
    int          dig_e;
    logic [15:0] upper;
    logic [3:0]  nib_e;
    logic        blank_e;
    logic [3:0]  an_e;
    cnt_e   = m_pos % P_DIV;
    dig_e   = m_pos / P_DIV;
    upper   = m_display >> (4 * dig_e);
    nib_e   = upper[3:0];
    blank_e = (cnt_e < P_BLANK) || !i_habilitar || (i_supr_ceros && dig_e > 0 && upper == 16'h0);
    an_e    = blank_e ? 4'b1111 : ~(4'b0001 << dig_e);
    compare("bits",      {12'h0, o_bits},      {12'h0, nib_e});
    compare("digito",    {14'h0, o_digito},    16'(dig_e));
    compare("anodos",    {12'h0, o_anodos},    {12'h0, an_e});
    compare("blanco",    {15'h0, o_blanco},    {15'h0, blank_e});
    compare("fin_trama", {15'h0, o_fin_trama}, {15'h0, m_fin});
  endtask

  task automatic applyStimulus(input logic rst, input logic carga, input logic [15:0] dato,
                               input logic hab, input logic supr);
    logic boundary;
    i_rst        = rst;
    i_carga      = carga;
    i_dato       = dato;
    i_habilitar  = hab;
    i_supr_ceros = supr;
    @(posedge i_clk);
    if (rst) begin
      m_pos     = 0;
      m_shadow  = 16'h0;
      m_display = 16'h0;
      m_fin     = 1'b0;
    end else begin
      boundary = hab && (m_pos == FRAME - 1);
      if (boundary)
        m_display = carga ? dato : m_shadow;
      if (carga)
        m_shadow = dato;
      if (hab)
        m_pos = (m_pos + 1) % FRAME;
      m_fin = boundary;
    end
    #1;
    checkOutput();
  endtask

  task automatic idle(input int n, input logic hab, input logic supr);
    for (int i = 0; i < n; i++)
      applyStimulus(1'b0, 1'b0, 16'($urandom), hab, supr);
  endtask

  task automatic advanceTo(input int target, input logic supr);
    for (int i = 0; i < FRAME + 2 && m_pos != target; i++)
      applyStimulus(1'b0, 1'b0, 16'($urandom), 1'b1, supr);
  endtask

  initial begin
    // reset, then reset again while load/enable are active
    applyStimulus(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 16'hFFFF, 1'b1, 1'b0);
    compare("rst_anodos", {12'h0, o_anodos}, 16'h000F);
    compare("rst_blanco", {15'h0, o_blanco}, 16'h0001);

    // 1234: first frame still shows zeros, the second shows 4,3,2,1
    applyStimulus(1'b0, 1'b1, 16'h1234, 1'b1, 1'b0);
    idle(2 * FRAME, 1'b1, 1'b0);

    // mid-frame load only takes effect at the next boundary
    advanceTo(8, 1'b0);
    applyStimulus(1'b0, 1'b1, 16'hABCD, 1'b1, 1'b0);
    advanceTo(18, 1'b0);
    compare("old_dig2", {12'h0, o_bits}, 16'h0002);
    advanceTo(2, 1'b0);
    compare("new_dig0", {12'h0, o_bits}, 16'h000D);

    // load in the boundary cycle itself bypasses the shadow
    advanceTo(FRAME - 1, 1'b0);
    applyStimulus(1'b0, 1'b1, 16'h5A5A, 1'b1, 1'b0);
    compare("bypass_fin", {15'h0, o_fin_trama}, 16'h0001);
    advanceTo(2, 1'b0);
    compare("bypass_dig0", {12'h0, o_bits}, 16'h000A);

    // leading-zero suppression of 0050
    applyStimulus(1'b0, 1'b1, 16'h0050, 1'b1, 1'b1);
    advanceTo(0, 1'b1);
    advanceTo(10, 1'b1);
    compare("supr_dig1", {12'h0, o_anodos}, 16'h000D);
    advanceTo(26, 1'b1);
    compare("supr_dig3", {12'h0, o_anodos}, 16'h000F);
    idle(FRAME, 1'b1, 1'b1);

    // all-zero display: only digit 0 lights
    applyStimulus(1'b0, 1'b1, 16'h0000, 1'b1, 1'b1);
    advanceTo(0, 1'b1);
    advanceTo(3, 1'b1);
    compare("zero_dig0", {12'h0, o_anodos}, 16'h000E);
    idle(FRAME, 1'b1, 1'b1);

    // enable dropped at cnt=4 of digit 2
    applyStimulus(1'b0, 1'b1, 16'h1234, 1'b1, 1'b0);
    advanceTo(0, 1'b0);
    advanceTo(20, 1'b0);
    idle(10, 1'b0, 1'b0);
    compare("hold_anodos", {12'h0, o_anodos}, 16'h000F);
    idle(3, 1'b1, 1'b0);
    compare("resume_dig2", {14'h0, o_digito}, 16'h0002);
    idle(1, 1'b1, 1'b0);
    compare("resume_dig3", {14'h0, o_digito}, 16'h0003);

    // reset during digit 2
    advanceTo(19, 1'b0);
    applyStimulus(1'b1, 1'b1, 16'hFFFF, 1'b1, 1'b1);
    compare("midrst_fin", {15'h0, o_fin_trama}, 16'h0000);
    compare("midrst_bits", {12'h0, o_bits}, 16'h0000);
    idle(FRAME + 4, 1'b1, 1'b0);

    // random traffic
    for (int i = 0; i < 600; i++)
      applyStimulus(($urandom_range(0, 99) == 0), ($urandom_range(0, 7) == 0), 16'($urandom),
                    ($urandom_range(0, 9) != 0), 1'($urandom));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/escaner_display_4d.md
ESCANER_DISPLAY_4D -- requirements
Module: escaner_display_4d

Interface
REQ-001 SHALL have parameter P_DIV, default 50000: clock cycles per digit slot; legal range P_DIV >= 2.
REQ-002 SHALL have parameter P_BLANK, default 500: blanking cycles at the start of each slot; legal range 0 <= P_BLANK < P_DIV.
REQ-003 SHALL have port i_clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port i_rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port i_dato  input  16  four hex nibbles; [3:0] is digit 0 (least significant), [15:12] is digit 3.
REQ-006 SHALL have port i_carga  input  1  load strobe; samples i_dato into the shadow register.
REQ-007 SHALL have port i_habilitar  input  1  scan enable.
REQ-008 SHALL have port i_supr_ceros  input  1  leading-zero suppression enable.
REQ-009 SHALL have port o_bits  output  4  nibble of the current digit, feeding the 4-bit-to-7-segment decoder.
REQ-010 SHALL have port o_anodos  output  4  digit selects, active-low; bit k drives digit k.
REQ-011 SHALL have port o_digito  output  2  current digit index.
REQ-012 SHALL have port o_blanco  output  1  high whenever all anodes are off.
REQ-013 SHALL have port o_fin_trama  output  1  one-cycle pulse at the end of each 4-digit frame.

Function
REQ-014 SHALL hold the registered state: slot counter cnt (0..P_DIV-1), digit index dig (0..3), a 16-bit shadow register and a 16-bit display register.
REQ-015 SHALL load shadow <= i_dato in any cycle with i_carga=1, independent of i_habilitar.
REQ-016 SHALL advance cnt by one per cycle while i_habilitar=1; at cnt=P_DIV-1 it wraps to 0 and dig increments modulo 4.
REQ-017 SHALL, on the wrap from dig=3 to dig=0 (the frame boundary), copy display <= shadow, or display <= i_dato when i_carga=1 in that same cycle (bypass); the display register changes at no other time.
REQ-018 SHALL pulse o_fin_trama high for exactly the cycle after the frame-boundary edge; it is low otherwise.
REQ-019 SHALL drive o_bits = display[4*dig+3 : 4*dig] and o_digito = dig, both derived only from registered state.
REQ-020 SHALL drive o_anodos = 4'b1111 when cnt < P_BLANK, i_habilitar=0, or the digit is suppressed; otherwise only bit dig is low.
REQ-021 SHALL treat digit k (k >= 1) as suppressed when i_supr_ceros=1 and display nibbles k..3 are all zero; digit 0 is never suppressed.
REQ-022 SHALL hold cnt and dig frozen while i_habilitar=0 and resume from the held values when it returns high.
REQ-023 SHALL drive o_blanco = 1 exactly when o_anodos = 4'b1111.

Reset
REQ-024 SHALL, in the cycle after i_rst=1 is sampled, set cnt=0, dig=0, shadow=0, display=0, o_bits=0, o_digito=0, o_anodos=4'b1111, o_blanco=1 and o_fin_trama=0.
REQ-025 SHALL give i_rst priority over i_carga and i_habilitar, including when it is asserted mid-slot or mid-frame.

Verification (P_DIV=8, P_BLANK=2)
REQ-026 SHALL cover: reset, load 16'h1234 with enable high -> frame 1 shows 0,0,0,0; from frame 2, the digit-0 slot has o_anodos=1111 for 2 cycles then 1110 with o_bits=4 for 6 cycles; digits 1..3 show 3,2,1.
REQ-027 SHALL cover: load 16'h0050 with i_supr_ceros=1 -> digits 3 and 2 keep o_anodos=1111 for their full slots; digit 1 shows 5 and digit 0 shows 0.
REQ-028 SHALL cover: display 16'h0000 with i_supr_ceros=1 -> only digit 0 lights (o_anodos=1110, o_bits=0).
REQ-029 SHALL cover: load 16'hABCD during the digit-1 slot of a frame showing 16'h1234 -> digits 2 and 3 still show 2 and 1; the next frame shows D,C,B,A; plus i_carga coinciding with the boundary cycle -> the new value is shown immediately.
REQ-030 SHALL cover: drop i_habilitar at cnt=4 of digit 2 for 10 cycles -> o_anodos=1111 and cnt held at 4; after re-enable the slot completes 3 more cycles before dig=3.
REQ-031 SHALL cover: assert i_rst during digit 2 -> next cycle matches every REQ-024 value and no o_fin_trama pulse occurs.
